// File: rtl/shift_pkg.sv
// Shared types and helpers for the multi-cycle shift sequencer.
// Purely declarative: no logic, no latency.
// No flow control of its own; used by shift_step and shift_sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    SHL = 2'b00,
    SHR = 2'b01,
    ROL = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Step for this pass: the smaller of what is left and one shifter pass.
  // Returned 32 bits wide; the caller keeps the low cnt_width bits, which
  // always hold the whole value because max_step fits in cnt_width bits.
  function automatic logic [31:0] min_step(input logic [31:0] remaining,
                                           input logic [31:0] max_step);
    return (remaining < max_step) ? remaining : max_step;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-pass combinational shifter: shifts/rotates a by k, producing out and carry.
// Latency: zero cycles (pure combinational).
// No flow control; the sequencer decides when the result is registered.
module shift_step
  import shift_pkg::*;
#(
  parameter int width     = 8,
  parameter int cnt_width = 3
) (
  input  logic [width-1:0]     a,
  input  logic [cnt_width-1:0] k,
  input  shift_op_e            op,
  output logic [width-1:0]     out,
  output logic                 co
);

  logic [width:0]     shl_t;
  logic [width:0]     shr_t;
  logic [2*width-1:0] rol_t;
  logic [2*width-1:0] ror_t;
  int                 rk;

  // Shift with a one-bit extension to catch the carry; rotate via a doubled operand
  always_comb begin
    rk    = int'(k) % width;
    shl_t = {1'b0, a} << k;
    shr_t = {a, 1'b0} >> k;
    rol_t = {a, a} << rk;
    ror_t = {a, a} >> rk;
    out   = a;
    co    = 1'b0;
    case (op)
      SHL: begin
        out = shl_t[width-1:0];
        co  = shl_t[width];
      end
      SHR: begin
        out = shr_t[width:1];
        co  = shr_t[0];
      end
      ROL: begin
        out = rol_t[2*width-1:width];
        co  = rol_t[width];          // equals out[0]
      end
      ROR: begin
        out = ror_t[width-1:0];
        co  = ror_t[width-1];        // equals out[width-1]
      end
      default: begin
        out = a;
        co  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller iterating shift_step over a working register.
// Latency: accept edge plus max(1, ceil(n_eff/MAX_STEP)) RUN cycles; SHIFT_ROT_MOD_EN reduces rotate counts mod width.
// Backpressure: req_ready only in IDLE; result held in DONE until rsp_ready, no queueing.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int width     = 8,
  parameter int cnt_width = 3,
  parameter int tot_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [width-1:0]     req_a,
  input  logic [tot_width-1:0] req_cnt,
  input  logic                 req_y,
  input  logic                 req_z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [width-1:0]     rsp_out,
  output logic                 rsp_co,
  output logic                 busy
);

  localparam int MAX_STEP = (1 << cnt_width) - 1;

  seq_state_e             state;
  seq_state_e             state_nxt;
  logic [width-1:0]       data;
  logic [tot_width-1:0]   remaining;
  shift_op_e              op;
  logic                   co;

  logic [cnt_width-1:0]   step;
  logic [width-1:0]       step_out;
  logic                   step_co;
  logic                   accept;
  logic                   last_step;
  logic [tot_width-1:0]   load_cnt;

  shift_step #(
    .width    (width),
    .cnt_width(cnt_width)
  ) u_step (
    .a  (data),
    .k  (step),
    .op (op),
    .out(step_out),
    .co (step_co)
  );

  // Per-cycle step size, final-step detect and count loaded on accept
  always_comb begin
    step      = cnt_width'(min_step(32'(remaining), 32'(MAX_STEP)));
    last_step = (remaining == tot_width'(step));
    accept    = req_valid && (state == IDLE);
    load_cnt  = req_cnt;
`ifdef SHIFT_ROT_MOD_EN
    // Rotating by a multiple of width is a no-op, so only the residue matters
    if (req_y) load_cnt = tot_width'(32'(req_cnt) % width);
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working register, remaining count, operation and carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      remaining <= '0;
      op        <= SHL;
      co        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          data      <= req_a;
          remaining <= load_cnt;
          op        <= shift_op_e'({req_y, req_z});
          co        <= 1'b0;
        end
        RUN: begin
          data      <= step_out;
          remaining <= remaining - tot_width'(step);
          co        <= step_co;
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decoded from state; result comes straight from registers
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == DONE);
    rsp_out   = data;
    rsp_co    = co;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed requests, expected results queued, monitor compares.
// Latency is measured from the accept edge to the first cycle rsp_valid is seen.
// Exercises response backpressure and asynchronous reset mid-operation.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = '0;
  logic [7:0] req_cnt = '0;
  logic       req_y = 1'b0;
  logic       req_z = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_out;
  logic       rsp_co;
  logic       busy;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

`ifdef SHIFT_ROT_MOD_EN
  localparam bit ROT_MOD = 1'b1;
`else
  localparam bit ROT_MOD = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] out;
    logic       co;
    logic [7:0] lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   acc_k = 0;
  bit   prev_vld = 1'b0;

  shift_sequencer #(
    .width    (8),
    .cnt_width(3),
    .tot_width(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_cnt  (req_cnt),
    .req_y    (req_y),
    .req_z    (req_z),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_out  (rsp_out),
    .rsp_co   (rsp_co),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Rotate latency depends on whether counts are reduced mod width on accept
  function automatic int rot_lat(input int mod_lat, input int full_lat);
    return ROT_MOD ? mod_lat : full_lat;
  endfunction

  // Monitor: measures latency on rsp_valid rise, compares result on handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
      acc_k    = 0;
    end else begin
      if (req_valid && req_ready) acc_k = cyc;
      if (rsp_valid && !prev_vld) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else chk("latency", 32'(cyc - acc_k - 1), 32'(exp_q[0].lat));
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        chk("rsp_out", 32'(rsp_out), 32'(exp_q[0].out));
        chk("rsp_co", 32'(rsp_co), 32'(exp_q[0].co));
        void'(exp_q.pop_front());
      end
      prev_vld = rsp_valid;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] n,
                       input bit push, input logic [7:0] eout, input logic eco, input int lat);
    int t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
    if (push) exp_q.push_back('{out: eout, co: eco, lat: 8'(lat)});
    {req_y, req_z} = op;
    req_a     = a;
    req_cnt   = n;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] n,
                     input logic [7:0] eout, input logic eco, input int lat);
    issue(op, a, n, 1'b1, eout, eco, lat);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_out",   32'(rsp_out),   32'd0);
    chk("rst_rsp_co",    32'(rsp_co),    32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors: op, a, n, expected out, expected co, expected latency
    run(OP_SHL, 8'h81, 8'd1,  8'h02, 1'b1, 1);
    run(OP_SHR, 8'h81, 8'd8,  8'h00, 1'b1, 2);
    run(OP_SHR, 8'h81, 8'd9,  8'h00, 1'b0, 2);
    run(OP_ROL, 8'h96, 8'd12, 8'h69, 1'b1, rot_lat(1, 2));
    run(OP_ROR, 8'h01, 8'd0,  8'h01, 1'b0, 1);
    run(OP_SHL, 8'hFF, 8'd0,  8'hFF, 1'b0, 1);
    run(OP_SHL, 8'h81, 8'd8,  8'h00, 1'b1, 2);
    run(OP_ROR, 8'h96, 8'd3,  8'hD2, 1'b1, 1);
    run(OP_ROR, 8'h01, 8'd17, 8'h80, 1'b1, rot_lat(1, 3));
    run(OP_SHR, 8'hF0, 8'd4,  8'h0F, 1'b0, 1);
    run(OP_SHR, 8'hF8, 8'd4,  8'h0F, 1'b1, 1);
    run(OP_ROL, 8'h5A, 8'd8,  8'h5A, 1'b0, rot_lat(1, 2));

    // Backpressure: hold the result in DONE while a competing request is offered
    rsp_ready = 1'b0;
    issue(OP_SHL, 8'h81, 8'd1, 1'b1, 8'h02, 1'b1, 1);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp_reach_done", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      {req_y, req_z} = OP_SHR;
      req_a     = 8'hFF;
      req_cnt   = 8'd2;
      req_valid = 1'b1;
      @(negedge clk);
      chk("bp_out",       32'(rsp_out),   32'h02);
      chk("bp_co",        32'(rsp_co),    32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_valid",     32'(rsp_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ignored_valid", 32'(rsp_valid), 32'd0);
      chk("bp_ignored_busy",  32'(busy),      32'd0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a long shift
    issue(OP_SHL, 8'hAB, 8'd200, 1'b0, 8'h00, 1'b0, 0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_out",   32'(rsp_out),   32'd0);
    chk("abort_rsp_co",    32'(rsp_co),    32'd0);
    chk("abort_busy",      32'(busy),      32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    run(OP_SHL, 8'h01, 8'd3, 8'h08, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller for the CPU's single-cycle shifter datapath; supports shift/rotate counts larger than one shifter pass allows.
- Latches a request, splits the total count into per-cycle steps of at most 2^cnt_width-1, iterates the shift-step unit over a working register, then presents result and carry.
- Sits between the CPU control unit (valid/ready request) and the writeback/flags stage (valid/ready response).

Parameters:
- width, 8, operand/result width in bits.
- cnt_width, 3, per-step count width; max step MAX_STEP = 2^cnt_width-1.
- tot_width, 8, width of the total requested count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  accept; equals (state==IDLE).
- req_a  in  width  operand.
- req_cnt  in  tot_width  total shift/rotate count n.
- req_y  in  1  op select high bit.
- req_z  in  1  op select low bit; {y,z}: 00 SHL, 01 SHR, 10 ROL, 11 ROR.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts result.
- rsp_out  out  width  result.
- rsp_co  out  1  carry.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_out=0, rsp_co=0, busy=0, req_ready=1 (follows IDLE), internal data/remaining/op registers=0.
- States:
  - IDLE: on req_valid && req_ready, latch a, op and remaining=n (see optional feature for rotates), then go to RUN.
  - RUN: each cycle applies step = min(remaining, MAX_STEP) to the working register; remaining -= step; capture the step's carry. Go to DONE when remaining reaches 0 after the step. n=0 still executes exactly one step with count 0.
  - DONE: rsp_valid=1; rsp_out and rsp_co are held stable until rsp_ready=1. On handshake, go to IDLE with rsp_valid=0.
- Latency: accept edge, plus steps = max(1, ceil(n_eff/MAX_STEP)) RUN cycles. rsp_valid rises after the last step edge.
- Per-step semantics (shift-step unit):
  - SHL: {co,out} = {0,a} << k.
  - SHR: {out,co} = {a,0} >> k.
  - ROL: out = rotl(a,k), co = out[0].
  - ROR: out = rotr(a,k), co = out[width-1].
  - k=0: SHL and SHR give co=0; rotates give out=a.
- Architectural results for total n:
  - SHL: out = a<<n, truncated. co = a[width-n] for 1<=n<=width, else 0.
  - SHR: out = a>>n. co = a[n-1] for 1<=n<=width, else 0.
  - ROL/ROR: rotate by n mod width. co = out[0] for ROL, out[width-1] for ROR.
  - Chaining steps must produce exactly these results.
- req_valid asserted outside IDLE is ignored; no queueing.
- rsp_ready outside DONE is ignored.
- Reset asserted mid-RUN or mid-DONE aborts the operation: outputs return to reset values immediately and the result is discarded.
- No back-to-back overlap. The next accept is possible in the cycle after the DONE handshake.

Optional Feature:
- Macro SHIFT_ROT_MOD_EN.
- Defined: on accept, ROL/ROR load remaining = n mod width, cutting latency.
- Undefined: rotates iterate the full n.
- rsp_out and rsp_co are identical either way; only latency differs. SHL/SHR are unaffected.

Decomposition:
- Package shift_pkg holds:
  - enum shift_op_e {SHL=2'b00, SHR=2'b01, ROL=2'b10, ROR=2'b11};
  - enum seq_state_e {IDLE, RUN, DONE};
  - function min_step(remaining) returning the cnt_width-bit step.
- Sub-module shift_step: combinational one-pass shifter (a, k, op -> out, co), instantiated once and parameterised by width/cnt_width.
- Sequencer FSM, counters and handshake stay in shift_sequencer.

Test Plan:
- SHL a=0x81 n=1 -> rsp_out=0x02, rsp_co=1, rsp_valid 1 cycle after accept.
- SHR a=0x81 n=8 -> 0x00, co=1 (steps 7,1, 2 cycles). SHR a=0x81 n=9 -> 0x00, co=0 (steps 7,2).
- ROL a=0x96 n=12 -> 0x69, co=1. Latency 1 cycle with SHIFT_ROT_MOD_EN, 2 cycles without.
- ROR a=0x01 n=0 -> 0x01, co=0 after exactly 1 RUN cycle. SHL a=0xFF n=0 -> 0xFF, co=0.
- Backpressure: hold rsp_ready=0 for 3 cycles in DONE while pulsing req_valid -> rsp_out/rsp_co stable, req_ready=0, request ignored; accept only after the handshake.
- Assert rst mid-RUN of SHL n=200 -> rsp_valid, rsp_out, rsp_co, busy go 0 immediately. After release req_ready=1, and a new SHL 0x01 n=3 returns 0x08, co=0.
